l2_cache_assoc: RTL and testbench
=================================

# l2_cache_assoc

Parametrised successor to the direct-mapped write-through L2: an N-way set-associative, write-allocate, **write-back** L2 cache between the L1 controller and main memory. It adds dirty tracking with victim write-back, round-robin replacement, a parametrised miss penalty, and an explicit `L1_ready` completion pulse. Default geometry is 16 KB (128 sets × 2 ways × 16 words × 32 bits) on the same 15-bit word address.

## Interface
- `ADDR_W`, 15, word-address width.
- `DATA_W`, 32, word width.
- `WORDS`, 16, words per block, power of 2; `OFF_W = log2(WORDS)`.
- `SETS`, 128, number of sets, power of 2; `IDX_W = log2(SETS)`.
- `WAYS`, 2, associativity, power of 2, 1..8; `TAG_W = ADDR_W - IDX_W - OFF_W`.
- `MM_PENALTY`, 160, artificial main-memory latency in cycles, ≥ 1.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `L1_word_address` in ADDR_W: {tag, index, offset}.
- `L1_wdata` in DATA_W: write data.
- `L1_read_request`, `L1_write_request` in 1: held by L1 until `L1_ready`.
- `L1_rdata` out DATA_W: read data, valid while `L1_ready` = 1.
- `L1_ready` out 1: one-cycle completion pulse.
- `L2_busy` out 1: transaction in progress.
- `MM_word_address` out ADDR_W: main-memory address.
- `MM_write_word` out DATA_W: main-memory write data.
- `MM_read_word` in DATA_W: main-memory read data, one cycle after the address.
- `MM_read_request`, `MM_write_request` out 1: main-memory strobes.
- `L2_statistics` out 32: {read_hit, read_miss, write_hit, write_miss}, each 8 bits and saturating at 255.
- `L2_writebacks` out 8: count of dirty evictions, saturating at 255.

## Operation
- **Per-way state:** `valid`, `dirty`, and a `TAG_W`-bit tag for every set/way. Each set also has a `log2(WAYS)` round-robin pointer.
- **States:** IDLE, COMPARE, PENALTY, WRITEBACK, REFILL, ACCESS, DONE.
- **IDLE:** clear the work counters. If either request is high, go to COMPARE.
- **COMPARE:**
  - If no request is present, go to IDLE.
  - On a hit (any valid way with a matching tag; the lowest index wins if several match), bump the hit counter and go to ACCESS.
  - On a miss, bump the miss counter, select the victim, and go to PENALTY.
  - If both requests are high, the write takes priority, for both the operation and the statistics.
- **Victim selection:** the lowest-index invalid way; if all ways are valid, the way at the set's pointer. The pointer increments modulo WAYS after every refill of that set.
- **PENALTY:** count `MM_PENALTY` cycles. Then go to WRITEBACK if the victim is valid and dirty, otherwise go to REFILL.
- **WRITEBACK:**
  - Issue `WORDS` consecutive cycles with `MM_write_request` = 1.
  - Address is {victim tag, index, k}; data is the victim's word k, for k = 0..WORDS-1.
  - Increment `L2_writebacks`, then go to REFILL.
- **REFILL:**
  - Issue `MM_read_request` = 1 for `WORDS` cycles with address {input tag, index, k}.
  - Word k is captured from `MM_read_word` the cycle after it is addressed, so REFILL lasts `WORDS + 1` cycles.
  - Then write the tag, set valid = 1 and dirty = 0, advance the pointer, and go to ACCESS.
- **ACCESS:**
  - On a write: store `L1_wdata` into the hit or refilled way, set dirty = 1. No main-memory traffic.
  - On a read: register the word into `L1_rdata`.
  - Go to DONE.
- **DONE:** `L1_ready` = 1 for this one cycle, then go to IDLE. L1 must drop its request in the DONE cycle.
- **Request withdrawn after COMPARE:** the refill still completes, but ACCESS performs no write and DONE is still pulsed.

## Timing
- **Reset (`reset_n` = 0, asynchronous):**
  - State is IDLE.
  - All valid, dirty and pointer bits are 0; all counters are 0.
  - `L1_rdata`, `MM_word_address` and `MM_write_word` are 0.
  - All strobes, `L1_ready` and `L2_busy` are 0.
  - Reset mid-transaction aborts the transaction with no further MM strobes. The partially refilled way stays invalid.
- **`L2_busy` formula:** state ∉ {IDLE, DONE}, OR (IDLE AND a request is present).
- **Hit latency:** request seen in cycle 0 (IDLE), COMPARE in cycle 1, ACCESS in cycle 2, `L1_ready` in cycle 3.
- **Clean miss latency:** 3 + `MM_PENALTY` + (WORDS + 1) cycles to `L1_ready`; 180 cycles with defaults.
- **Dirty miss latency:** the clean miss latency plus `WORDS` cycles; 196 cycles with defaults.
- **Write strobes:** `MM_write_request` is never asserted in the same cycle as `MM_read_request`.
- **Counter saturation:** every statistics counter stays at 255 once it reaches 255.
- **Index bits:** the set index is always `L1_word_address[OFF_W +: IDX_W]`, with no modular wrap beyond the set range.

## Test plan
- **Cold read miss, then hit:** read address 0x0123 after reset.
  - Required: 16 MM reads at 0x0120..0x012F and `L1_ready` at cycle 180 carrying MM word 3.
  - Repeat the read: `L1_ready` at cycle 3 and `L2_statistics` = 0x01010000.
- **Write hit marks dirty:** write 0xDEADBEEF to 0x0123 after the line is resident.
  - Required: no MM strobe; a following read of 0x0123 returns 0xDEADBEEF.
- **Eviction with write-back:** fill both ways of set 0x12 with tags 0 and 1, dirtying tag 0; then read tag 2 in the same set.
  - Required: the victim is way 0.
  - Required: 16 MM writes at 0x0120..0x012F, including the dirty word, followed by the refill.
  - Required: `L2_writebacks` = 1.
- **Clean eviction:** evict a clean line.
  - Required: no `MM_write_request`; miss latency of 180 cycles.
- **Simultaneous read+write:** both requests high on a hit.
  - Required: the write is performed and `write_hit` increments; `read_hit` is unchanged.
- **Reset mid-refill:** pull `reset_n` low during REFILL word 5.
  - Required: all outputs 0 immediately and the line is invalid.
  - Required: re-reading the same address misses again (`read_miss` = 1 after reset).

Source files
------------

// File: rtl/l2_cache_assoc_if.sv
// L1-side and main-memory-side signals of the set-associative write-back L2.
// The cache connects through the slave modport; the requester/memory side uses master.
interface l2_cache_assoc_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] L1_word_address;
  logic [DATA_W-1:0] L1_wdata;
  logic              L1_read_request;
  logic              L1_write_request;
  logic [DATA_W-1:0] L1_rdata;
  logic              L1_ready;
  logic              L2_busy;
  logic [ADDR_W-1:0] MM_word_address;
  logic [DATA_W-1:0] MM_write_word;
  logic [DATA_W-1:0] MM_read_word;
  logic              MM_read_request;
  logic              MM_write_request;
  logic [31:0]       L2_statistics;
  logic [7:0]        L2_writebacks;

  modport slave (
    input  L1_word_address, L1_wdata, L1_read_request, L1_write_request, MM_read_word,
    output L1_rdata, L1_ready, L2_busy, MM_word_address, MM_write_word,
           MM_read_request, MM_write_request, L2_statistics, L2_writebacks
  );

  modport master (
    output L1_word_address, L1_wdata, L1_read_request, L1_write_request, MM_read_word,
    input  L1_rdata, L1_ready, L2_busy, MM_word_address, MM_write_word,
           MM_read_request, MM_write_request, L2_statistics, L2_writebacks
  );
endinterface

// File: rtl/l2_cache_assoc.sv
// N-way set-associative, write-allocate, write-back L2 with round-robin replacement,
// dirty-victim write-back and an artificial main-memory penalty before each line fill.
module l2_cache_assoc #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 32,
  parameter int WORDS      = 16,
  parameter int SETS       = 128,
  parameter int WAYS       = 2,
  parameter int MM_PENALTY = 160
) (
  input logic            clk,
  input logic            reset_n,
  l2_cache_assoc_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int CNT_W = $clog2(MM_PENALTY + WORDS + 2);

  typedef enum logic [2:0] {
    S_IDLE, S_COMPARE, S_PENALTY, S_WRITEBACK, S_REFILL, S_ACCESS, S_DONE
  } state_t;

  state_t r_state, w_next;

  logic [SETS-1:0][WAYS-1:0]  r_valid, r_dirty;
  logic [SETS-1:0][WAY_W-1:0] r_ptr;
  logic [TAG_W-1:0]           r_tag  [SETS][WAYS];
  logic [DATA_W-1:0]          r_data [SETS][WAYS][WORDS];

  logic [ADDR_W-1:0] r_addr;
  logic              r_wr;
  logic [WAY_W-1:0]  r_way;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_rdata;
  logic [7:0]        r_rd_hit, r_rd_miss, r_wr_hit, r_wr_miss, r_wb;

  logic              w_req;
  logic [IDX_W-1:0]  w_idx_in, r_idx_q;
  logic [TAG_W-1:0]  w_tag_in, w_tag_q;
  logic [OFF_W-1:0]  w_off_q, w_cnt_off, w_cap_off;
  logic              w_hit;
  logic [WAY_W-1:0]  w_hit_way, w_vict;
  logic              w_last_refill, w_do_write;

  function automatic logic [7:0] sat8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_req         = bus.L1_read_request | bus.L1_write_request;
  assign w_idx_in      = bus.L1_word_address[OFF_W +: IDX_W];
  assign w_tag_in      = bus.L1_word_address[ADDR_W-1 -: TAG_W];
  assign r_idx_q       = r_addr[OFF_W +: IDX_W];
  assign w_tag_q       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_off_q       = r_addr[OFF_W-1:0];
  assign w_cnt_off     = r_cnt[OFF_W-1:0];
  assign w_cap_off     = OFF_W'(r_cnt - 1'b1);
  assign w_last_refill = (r_state == S_REFILL) && (r_cnt == CNT_W'(WORDS));
  // A withdrawn write request suppresses the store but not the completion pulse.
  assign w_do_write    = (r_state == S_ACCESS) && r_wr && bus.L1_write_request;

  // Descending scans so the lowest matching / lowest invalid way wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_vict    = r_ptr[w_idx_in];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (r_valid[w_idx_in][w] && (r_tag[w_idx_in][w] == w_tag_in)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!r_valid[w_idx_in][w]) w_vict = WAY_W'(w);
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:      if (w_req) w_next = S_COMPARE;
      S_COMPARE:   if (!w_req)     w_next = S_IDLE;
                   else if (w_hit) w_next = S_ACCESS;
                   else            w_next = S_PENALTY;
      S_PENALTY:   if (r_cnt == CNT_W'(MM_PENALTY-1))
                     w_next = (r_valid[r_idx_q][r_way] && r_dirty[r_idx_q][r_way])
                              ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: if (r_cnt == CNT_W'(WORDS-1)) w_next = S_REFILL;
      S_REFILL:    if (w_last_refill) w_next = S_ACCESS;
      S_ACCESS:    w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // MM strobes decode straight from state, so an async reset silences them at once.
  always_comb begin
    bus.MM_read_request  = (r_state == S_REFILL) && (r_cnt < CNT_W'(WORDS));
    bus.MM_write_request = (r_state == S_WRITEBACK);
    bus.MM_word_address  = '0;
    bus.MM_write_word    = '0;
    if (bus.MM_write_request) begin
      bus.MM_word_address = {r_tag[r_idx_q][r_way], r_idx_q, w_cnt_off};
      bus.MM_write_word   = r_data[r_idx_q][r_way][w_cnt_off];
    end else if (bus.MM_read_request) begin
      bus.MM_word_address = {w_tag_q, r_idx_q, w_cnt_off};
    end
  end

  assign bus.L1_ready      = (r_state == S_DONE);
  assign bus.L2_busy       = ((r_state != S_IDLE) && (r_state != S_DONE)) ||
                             ((r_state == S_IDLE) && w_req);
  assign bus.L1_rdata      = r_rdata;
  assign bus.L2_statistics = {r_rd_hit, r_rd_miss, r_wr_hit, r_wr_miss};
  assign bus.L2_writebacks = r_wb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_valid   <= '0;
      r_dirty   <= '0;
      r_ptr     <= '0;
      r_addr    <= '0;
      r_wr      <= 1'b0;
      r_way     <= '0;
      r_rdata   <= '0;
      r_rd_hit  <= '0;
      r_rd_miss <= '0;
      r_wr_hit  <= '0;
      r_wr_miss <= '0;
      r_wb      <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= ((w_next != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 1'b1;
      case (r_state)
        S_COMPARE: if (w_req) begin
          r_addr <= bus.L1_word_address;
          r_wr   <= bus.L1_write_request;
          r_way  <= w_hit ? w_hit_way : w_vict;
          case ({bus.L1_write_request, w_hit})
            2'b11:   r_wr_hit  <= sat8(r_wr_hit);
            2'b10:   r_wr_miss <= sat8(r_wr_miss);
            2'b01:   r_rd_hit  <= sat8(r_rd_hit);
            default: r_rd_miss <= sat8(r_rd_miss);
          endcase
        end
        S_WRITEBACK: if (r_cnt == CNT_W'(WORDS-1)) r_wb <= sat8(r_wb);
        S_REFILL: if (w_last_refill) begin
          r_valid[r_idx_q][r_way] <= 1'b1;
          r_dirty[r_idx_q][r_way] <= 1'b0;
          r_ptr[r_idx_q] <= (r_ptr[r_idx_q] == WAY_W'(WAYS-1)) ? '0 : r_ptr[r_idx_q] + 1'b1;
        end
        S_ACCESS: begin
          if (w_do_write) r_dirty[r_idx_q][r_way] <= 1'b1;
          if (!r_wr)      r_rdata <= r_data[r_idx_q][r_way][w_off_q];
        end
        default: ;
      endcase
    end
  end

  // Arrays carry no reset; validity alone decides whether their contents matter.
  always_ff @(posedge clk) begin
    if ((r_state == S_REFILL) && (r_cnt != '0))
      r_data[r_idx_q][r_way][w_cap_off] <= bus.MM_read_word;
    if (w_last_refill)
      r_tag[r_idx_q][r_way] <= w_tag_q;
    if (w_do_write)
      r_data[r_idx_q][r_way][w_off_q] <= bus.L1_wdata;
  end
endmodule

// File: tb/tb_l2_cache_assoc.sv
// Bench for l2_cache_assoc: directed vector table, reset-mid-refill sequence and
// randomized traffic checked against an architectural cache/memory model.
module tb_l2_cache_assoc;
  localparam int AW = 15, DW = 32, TMO = 1000;
  localparam int LAT_HIT = 3, LAT_CLEAN = 3 + 160 + 17, LAT_DIRTY = LAT_CLEAN + 16;

  logic clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  l2_cache_assoc_if #(.ADDR_W(AW), .DATA_W(DW)) ifc();
  l2_cache_assoc #(.ADDR_W(AW), .DATA_W(DW), .WORDS(16), .SETS(128), .WAYS(2), .MM_PENALTY(160))
    dut (.clk(clk), .reset_n(reset_n), .bus(ifc.slave));

  // main memory: background pattern until first written
  bit          mm_w [0:32767];
  logic [31:0] mm_d [0:32767];
  function automatic logic [31:0] mm_init(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
  endfunction
  function automatic logic [31:0] mm_rd(input int a);
    return mm_w[a] ? mm_d[a] : mm_init(a);
  endfunction
  always @(posedge clk) begin
    if (ifc.MM_write_request) begin
      mm_w[ifc.MM_word_address] <= 1'b1;
      mm_d[ifc.MM_word_address] <= ifc.MM_write_word;
    end
    if (ifc.MM_read_request) ifc.MM_read_word <= mm_rd(int'(ifc.MM_word_address));
  end

  int nchk = 0, nerr = 0;
  logic [14:0] rq[$], wq[$];
  bit g_ovl, g_busy0, g_busy_done;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit seq_ok(input logic [14:0] q[$], input int base);
    if (q.size() != 16) return 1'b0;
    for (int k = 0; k < 16; k++) if (int'(q[k]) != base + k) return 1'b0;
    return 1'b1;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the DONE cycle.
  task automatic do_txn(input bit rd, input bit wr, input logic [14:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rdat);
    rq.delete(); wq.delete(); g_ovl = 0;
    ifc.L1_word_address = a; ifc.L1_wdata = wd;
    ifc.L1_read_request = rd; ifc.L1_write_request = wr;
    #1 g_busy0 = ifc.L2_busy;
    lat = 0;
    while (lat <= TMO) begin
      @(posedge clk); @(negedge clk); lat++;
      if (ifc.MM_read_request)  rq.push_back(ifc.MM_word_address);
      if (ifc.MM_write_request) wq.push_back(ifc.MM_word_address);
      if (ifc.MM_read_request && ifc.MM_write_request) g_ovl = 1;
      if (ifc.L1_ready) break;
    end
    if (lat > TMO) chk("txn_timeout", 32'(lat), 32'(TMO));
    g_busy_done = ifc.L2_busy;
    rdat = ifc.L1_rdata;
    ifc.L1_read_request = 0; ifc.L1_write_request = 0;
    @(negedge clk);
  endtask

  task automatic strobe_chk(input string nm, input int rbase, input int wbase);
    chk({nm, "_nrd"}, 32'(rq.size()), (rbase >= 0) ? 32'd16 : 32'd0);
    chk({nm, "_nwr"}, 32'(wq.size()), (wbase >= 0) ? 32'd16 : 32'd0);
    if (rbase >= 0) chk({nm, "_rdseq"}, 32'(seq_ok(rq, rbase)), 32'd1);
    if (wbase >= 0) chk({nm, "_wrseq"}, 32'(seq_ok(wq, wbase)), 32'd1);
    chk({nm, "_ovl"}, 32'(g_ovl), 32'd0);
    chk({nm, "_busy_idle"}, 32'(g_busy0), 32'd1);
    chk({nm, "_busy_done"}, 32'(g_busy_done), 32'd0);
  endtask

  task automatic do_reset();
    reset_n = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
  endtask

  task automatic reset_outs_chk(input string nm);
    chk({nm, "_rdata"}, ifc.L1_rdata, 32'h0);
    chk({nm, "_ready"}, 32'(ifc.L1_ready), 32'h0);
    chk({nm, "_busy"}, 32'(ifc.L2_busy), 32'h0);
    chk({nm, "_mmaddr"}, 32'(ifc.MM_word_address), 32'h0);
    chk({nm, "_mmwd"}, ifc.MM_write_word, 32'h0);
    chk({nm, "_mmrq"}, 32'(ifc.MM_read_request), 32'h0);
    chk({nm, "_mmwq"}, 32'(ifc.MM_write_request), 32'h0);
    chk({nm, "_stats"}, ifc.L2_statistics, 32'h0);
    chk({nm, "_wbs"}, 32'(ifc.L2_writebacks), 32'h0);
  endtask

  // ---------------- architectural model ----------------
  bit          mv [128][2], md [128][2];
  int          mt [128][2], mp [128];
  int          e_rh, e_rm, e_wh, e_wm, e_wb;
  logic [31:0] arch [int];

  function automatic int inc8(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction
  function automatic logic [31:0] arch_rd(input int a);
    return arch.exists(a) ? arch[a] : mm_rd(a);
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 128; s++) begin
      mp[s] = 0;
      for (int w = 0; w < 2; w++) begin mv[s][w] = 0; md[s][w] = 0; mt[s][w] = 0; end
    end
    e_rh = 0; e_rm = 0; e_wh = 0; e_wm = 0; e_wb = 0;
    arch.delete();
  endtask

  task automatic model_txn(input bit rd, input bit wr, input logic [14:0] a, input logic [31:0] wd);
    int s, tg, way, elat, lat, etag, bad;
    bit hit, dev;
    logic [31:0] exp, got;
    s = (int'(a) >> 4) & 127; tg = int'(a) >> 11;
    hit = 0; way = -1; dev = 0; etag = 0;
    for (int w = 0; w < 2; w++) if (!hit && mv[s][w] && mt[s][w] == tg) begin hit = 1; way = w; end
    if (!hit) begin
      for (int w = 0; w < 2; w++) if (!mv[s][w] && way < 0) way = w;
      if (way < 0) way = mp[s];
      dev = mv[s][way] && md[s][way];
      etag = mt[s][way];
      mv[s][way] = 1; md[s][way] = 0; mt[s][way] = tg;
      mp[s] = (mp[s] + 1) % 2;
      if (dev) e_wb = inc8(e_wb);
    end
    elat = hit ? LAT_HIT : (dev ? LAT_DIRTY : LAT_CLEAN);
    exp = arch_rd(int'(a));
    if (wr) begin
      if (hit) e_wh = inc8(e_wh); else e_wm = inc8(e_wm);
      arch[int'(a)] = wd; md[s][way] = 1;
    end else begin
      if (hit) e_rh = inc8(e_rh); else e_rm = inc8(e_rm);
    end
    do_txn(rd, wr, a, wd, lat, got);
    chk($sformatf("rnd_lat_%h", a), 32'(lat), 32'(elat));
    if (!wr) chk($sformatf("rnd_data_%h", a), got, exp);
    chk("rnd_stats", ifc.L2_statistics, {8'(e_rh), 8'(e_rm), 8'(e_wh), 8'(e_wm)});
    chk("rnd_wbs", 32'(ifc.L2_writebacks), 32'(e_wb));
    strobe_chk("rnd", hit ? -1 : int'(a) & ~15, dev ? ((etag << 11) | (s << 4)) : -1);
    if (dev) begin
      bad = 0;
      for (int k = 0; k < 16; k++)
        if (mm_rd((etag << 11) | (s << 4) | k) !== arch_rd((etag << 11) | (s << 4) | k)) bad++;
      chk("rnd_wb_data", 32'(bad), 32'd0);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit rd, wr; logic [14:0] addr; logic [31:0] wdata;
    int lat; bit chkd; logic [31:0] rdata; logic [31:0] stats; int wbs; int rbase; int wbase;
  } vec_t;
  vec_t tv[11];

  initial begin
    int lat, n;
    logic [31:0] got;
    int sel[4] = '{0, 1, 18, 127};

    ifc.L1_word_address = '0; ifc.L1_wdata = '0;
    ifc.L1_read_request = 0; ifc.L1_write_request = 0;
    repeat (3) @(negedge clk);
    reset_outs_chk("reset");
    reset_n = 1;
    @(negedge clk);

    tv[0]  = '{1, 0, 15'h0123, 32'h0,        LAT_CLEAN, 1, mm_init('h123),  32'h00010000, 0, 'h120,  -1};
    tv[1]  = '{1, 0, 15'h0123, 32'h0,        LAT_HIT,   1, mm_init('h123),  32'h01010000, 0, -1,     -1};
    tv[2]  = '{0, 1, 15'h0123, 32'hDEADBEEF, LAT_HIT,   0, 32'h0,           32'h01010100, 0, -1,     -1};
    tv[3]  = '{1, 0, 15'h0123, 32'h0,        LAT_HIT,   1, 32'hDEADBEEF,    32'h02010100, 0, -1,     -1};
    tv[4]  = '{1, 0, 15'h0925, 32'h0,        LAT_CLEAN, 1, mm_init('h925),  32'h02020100, 0, 'h920,  -1};
    tv[5]  = '{1, 0, 15'h1127, 32'h0,        LAT_DIRTY, 1, mm_init('h1127), 32'h02030100, 1, 'h1120, 'h120};
    tv[6]  = '{1, 0, 15'h0123, 32'h0,        LAT_CLEAN, 1, 32'hDEADBEEF,    32'h02040100, 1, 'h120,  -1};
    tv[7]  = '{1, 1, 15'h0123, 32'h12345678, LAT_HIT,   0, 32'h0,           32'h02040200, 1, -1,     -1};
    tv[8]  = '{1, 0, 15'h0123, 32'h0,        LAT_HIT,   1, 32'h12345678,    32'h03040200, 1, -1,     -1};
    tv[9]  = '{0, 1, 15'h0200, 32'hCAFEF00D, LAT_CLEAN, 0, 32'h0,           32'h03040201, 1, 'h200,  -1};
    tv[10] = '{1, 0, 15'h0200, 32'h0,        LAT_HIT,   1, 32'hCAFEF00D,    32'h04040201, 1, -1,     -1};

    for (int i = 0; i < 11; i++) begin
      do_txn(tv[i].rd, tv[i].wr, tv[i].addr, tv[i].wdata, lat, got);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'(tv[i].lat));
      if (tv[i].chkd) chk($sformatf("v%0d_data", i), got, tv[i].rdata);
      chk($sformatf("v%0d_stats", i), ifc.L2_statistics, tv[i].stats);
      chk($sformatf("v%0d_wbs", i), 32'(ifc.L2_writebacks), 32'(tv[i].wbs));
      strobe_chk($sformatf("v%0d", i), tv[i].rbase, tv[i].wbase);
      if (i == 5) chk("v5_dirty_word_in_mm", mm_rd('h123), 32'hDEADBEEF);
    end

    // reset while REFILL is addressing word 5
    do_reset();
    ifc.L1_word_address = 15'h0345; ifc.L1_read_request = 1;
    n = 0;
    for (int c = 0; c < 400 && n < 6; c++) begin
      @(posedge clk); @(negedge clk);
      if (ifc.MM_read_request) n++;
    end
    chk("mid_reach_word5", 32'(n), 32'd6);
    chk("mid_word5_addr", 32'(ifc.MM_word_address), 32'h0345);
    ifc.L1_read_request = 0;
    #1 reset_n = 0;
    #1 reset_outs_chk("mid");
    repeat (2) @(negedge clk);
    reset_n = 1;
    @(negedge clk);
    do_txn(1, 0, 15'h0345, 32'h0, lat, got);
    chk("mid_reread_lat", 32'(lat), 32'(LAT_CLEAN));
    chk("mid_reread_stats", ifc.L2_statistics, 32'h00010000);
    chk("mid_reread_data", got, mm_rd('h345));

    // randomized traffic on a few hot sets, then read-hit counter saturation
    do_reset();
    model_reset();
    for (int t = 0; t < 150; t++) begin
      int op;
      logic [14:0] a;
      op = $urandom_range(0, 2);
      a  = 15'(($urandom_range(0, 3) << 11) | (sel[$urandom_range(0, 3)] << 4) | $urandom_range(0, 15));
      model_txn(op != 1, op != 0, a, $urandom);
    end
    for (int t = 0; t < 270; t++) model_txn(1, 0, 15'h07F5, 32'h0);
    chk("sat_read_hit", 32'(ifc.L2_statistics[31:24]), 32'd255);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
